// File: rtl/key_stream_if.sv
// key_stream_if: producer/consumer PicoBlaze port bundle for key_stream_ctrl.
// PROD_IRQ_EN adds the producer interrupt pair.
`default_nettype none

interface key_stream_if;
  logic [7:0] prod_port_id;
  logic       prod_write_strobe;
  logic [7:0] prod_out_port;
  logic [7:0] prod_in_port;
  logic [7:0] cons_port_id;
  logic       cons_read_strobe;
  logic       cons_write_strobe;
  logic [7:0] cons_out_port;
  logic [7:0] cons_in_port;
  logic       cons_interrupt;
  logic       cons_interrupt_ack;
`ifdef PROD_IRQ_EN
  logic       prod_interrupt;
  logic       prod_interrupt_ack;
`endif

  modport master (
    output prod_port_id, prod_write_strobe, prod_out_port,
    output cons_port_id, cons_read_strobe, cons_write_strobe, cons_out_port, cons_interrupt_ack,
`ifdef PROD_IRQ_EN
    output prod_interrupt_ack,
    input  prod_interrupt,
`endif
    input  prod_in_port, cons_in_port, cons_interrupt
  );

  modport slave (
    input  prod_port_id, prod_write_strobe, prod_out_port,
    input  cons_port_id, cons_read_strobe, cons_write_strobe, cons_out_port, cons_interrupt_ack,
`ifdef PROD_IRQ_EN
    input  prod_interrupt_ack,
    output prod_interrupt,
`endif
    output prod_in_port, cons_in_port, cons_interrupt
  );
endinterface

`default_nettype wire

// File: rtl/key_stream_ctrl.sv
// key_stream_ctrl: key-byte FIFO mailbox between producer and consumer PicoBlaze with threshold/ack IRQ.
// Optional macro PROD_IRQ_EN adds a low-water interrupt toward the producer.
`default_nettype none

module key_stream_ctrl #(
  parameter int         DEPTH          = 16,
  parameter int         AW             = 4,
  parameter logic [7:0] PROD_KEY_PORT  = 8'h01,
  parameter logic [7:0] PROD_STAT_PORT = 8'h02,
  parameter logic [7:0] CONS_KEY_PORT  = 8'h00,
  parameter logic [7:0] CONS_STAT_PORT = 8'h01,
  parameter logic [7:0] CONS_CTRL_PORT = 8'h02,
  parameter logic [7:0] CONS_THR_PORT  = 8'h03
) (
  input  logic         clk,
  input  logic         reset,
  key_stream_if.slave  bus
);

  localparam logic [AW:0] DEPTH_P  = (AW+1)'(DEPTH);
  localparam logic [4:0]  DEPTH_5  = 5'(DEPTH);
  localparam logic [4:0]  LOW_WATER = 5'(DEPTH / 4);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } irq_state_t;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic [4:0]  count5;
  logic [4:0]  thr;
  logic [4:0]  thr_new;
  logic        ovf;
  logic        unf;
  logic        irq_en;
  logic        empty;
  logic        full;
  logic        push_req;
  logic        pop_req;
  logic        push_ok;
  logic        pop_ok;
  logic        ctrl_wr;
  logic        thr_wr;
  logic        flush;
  logic        flag_clr;
  logic        prod_irq_bit;
  logic        unused_out_bits;
  irq_state_t  cons_state;

  assign count  = wr_ptr - rd_ptr;
  assign count5 = 5'(count);
  assign empty  = (count == '0);
  assign full   = (count == DEPTH_P);

  assign push_req = bus.prod_write_strobe && (bus.prod_port_id == PROD_KEY_PORT);
  assign pop_req  = bus.cons_read_strobe  && (bus.cons_port_id == CONS_KEY_PORT);
  assign ctrl_wr  = bus.cons_write_strobe && (bus.cons_port_id == CONS_CTRL_PORT);
  assign thr_wr   = bus.cons_write_strobe && (bus.cons_port_id == CONS_THR_PORT);
  assign flush    = ctrl_wr && bus.cons_out_port[1];
  assign flag_clr = ctrl_wr && bus.cons_out_port[2];

  // A full FIFO still accepts a byte when the consumer frees a slot on the same edge.
  assign pop_ok  = pop_req && !empty;
  assign push_ok = push_req && (!full || pop_ok);

  assign unused_out_bits = ^bus.cons_out_port[7:5];

  always_comb begin
    thr_new = bus.cons_out_port[4:0];
    if (thr_new == 5'd0) begin
      thr_new = 5'd1;
    end else if (thr_new > DEPTH_5) begin
      thr_new = DEPTH_5;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      irq_en <= 1'b1;
      thr    <= 5'd1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
      ovf <= (flag_clr ? 1'b0 : ovf) | (push_req && !push_ok);
      unf <= (flag_clr ? 1'b0 : unf) | (pop_req && empty);
      if (ctrl_wr) irq_en <= bus.cons_out_port[0];
      if (thr_wr)  thr    <= thr_new;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr[AW-1:0]] <= bus.prod_out_port;
    end
  end

  // Leaving SERVICE needs the level to fall below thr, so one fill raises at most one interrupt.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cons_state         <= S_IDLE;
      bus.cons_interrupt <= 1'b0;
    end else begin
      case (cons_state)
        S_IDLE: begin
          if (irq_en && (count5 >= thr)) begin
            cons_state         <= S_ASSERT;
            bus.cons_interrupt <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (!irq_en) begin
            cons_state         <= S_IDLE;
            bus.cons_interrupt <= 1'b0;
          end else if (bus.cons_interrupt_ack) begin
            cons_state         <= S_SERVICE;
            bus.cons_interrupt <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (count5 < thr) begin
            cons_state <= S_IDLE;
          end
          bus.cons_interrupt <= 1'b0;
        end
        default: begin
          cons_state         <= S_IDLE;
          bus.cons_interrupt <= 1'b0;
        end
      endcase
    end
  end

`ifdef PROD_IRQ_EN
  irq_state_t prod_state;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      prod_state         <= S_IDLE;
      bus.prod_interrupt <= 1'b0;
    end else begin
      case (prod_state)
        S_IDLE: begin
          if (count5 <= LOW_WATER) begin
            prod_state         <= S_ASSERT;
            bus.prod_interrupt <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (bus.prod_interrupt_ack) begin
            prod_state         <= S_SERVICE;
            bus.prod_interrupt <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (count5 > LOW_WATER) begin
            prod_state <= S_IDLE;
          end
          bus.prod_interrupt <= 1'b0;
        end
        default: begin
          prod_state         <= S_IDLE;
          bus.prod_interrupt <= 1'b0;
        end
      endcase
    end
  end

  assign prod_irq_bit = bus.prod_interrupt;
`else
  logic unused_low_water;
  assign unused_low_water = ^LOW_WATER;
  assign prod_irq_bit     = 1'b0;
`endif

  always_comb begin
    bus.prod_in_port = 8'h00;
    if (bus.prod_port_id == PROD_STAT_PORT) begin
      bus.prod_in_port = {5'b0, prod_irq_bit, ovf, full};
    end
  end

  always_comb begin
    bus.cons_in_port = 8'h00;
    if (bus.cons_port_id == CONS_KEY_PORT) begin
      bus.cons_in_port = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    end else if (bus.cons_port_id == CONS_STAT_PORT) begin
      bus.cons_in_port = {1'b0, unf, ovf, count5};
    end
  end

endmodule

`default_nettype wire
